// File: rtl/safe_ctrl.sv
// Digital-safe sequencer: unlocks on a pass event, counts failed attempts,
// enforces a timed lockout, and pulses the keypad entry-clear between attempts.
module safe_ctrl #(
  parameter int unsigned MAX_TRIES   = 3,
  parameter int unsigned UNLOCK_CYC  = 250_000_000,
  parameter int unsigned LOCKOUT_CYC = 1_500_000_000,
  parameter int unsigned CLR_CYC     = 4
) (
  input  logic       clk,
  input  logic       reset_n,
  input  logic       pass,
  input  logic       fail,
  input  logic       door_closed,
  output logic       lock_en,
  output logic       entry_clr_n,
  output logic       lockout,
  output logic [2:0] tries,
  output logic [1:0] status
);

  typedef enum logic [1:0] {
    S_IDLE    = 2'b00,
    S_OPEN    = 2'b01,
    S_LOCKOUT = 2'b10,
    S_CLEAR   = 2'b11
  } state_t;

  localparam logic [31:0] CLR_LOAD     = 32'(CLR_CYC - 1);
  localparam logic [31:0] UNLOCK_LOAD  = 32'(UNLOCK_CYC - 1);
  localparam logic [31:0] LOCKOUT_LOAD = 32'(LOCKOUT_CYC - 1);

  state_t      state;
  logic [31:0] tmr;
  logic        dc_m, dc_s, dc_q;
  logic        pass_q, fail_q;
  logic        pass_rise, fail_rise, dc_rise, last_try;

  // Door synchronizer (reset to "closed") and input edge-detect flops
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      dc_m   <= 1'b1;
      dc_s   <= 1'b1;
      dc_q   <= 1'b1;
      pass_q <= 1'b0;
      fail_q <= 1'b0;
    end else begin
      dc_m   <= door_closed;
      dc_s   <= dc_m;
      dc_q   <= dc_s;
      pass_q <= pass;
      fail_q <= fail;
    end
  end

  assign pass_rise = pass & ~pass_q;
  assign fail_rise = fail & ~fail_q;
  assign dc_rise   = dc_s & ~dc_q;
  assign last_try  = (32'(tries) + 32'd1) >= MAX_TRIES;
  assign status    = state;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state       <= S_CLEAR;
      tmr         <= CLR_LOAD;
      lock_en     <= 1'b0;
      entry_clr_n <= 1'b0;
      lockout     <= 1'b0;
      tries       <= 3'd0;
    end else begin
      case (state)
        S_CLEAR: begin
          if (tmr == 32'd0) begin
            state       <= S_IDLE;
            entry_clr_n <= 1'b1;
          end else begin
            tmr <= tmr - 32'd1;
          end
        end
        S_IDLE: begin
          // A simultaneous fail edge is dropped when pass rises
          if (pass_rise) begin
            state       <= S_OPEN;
            lock_en     <= 1'b1;
            entry_clr_n <= 1'b0;
            tries       <= 3'd0;
            tmr         <= UNLOCK_LOAD;
          end else if (fail_rise) begin
            entry_clr_n <= 1'b0;
            if (last_try) begin
              state   <= S_LOCKOUT;
              tries   <= 3'(MAX_TRIES);
              lockout <= 1'b1;
              tmr     <= LOCKOUT_LOAD;
            end else begin
              state <= S_CLEAR;
              tries <= tries + 3'd1;
              tmr   <= CLR_LOAD;
            end
          end
        end
        S_OPEN: begin
          // Relock on door close edge, or on timeout once the door is shut
          if (dc_rise || (tmr == 32'd0 && dc_s)) begin
            state   <= S_CLEAR;
            lock_en <= 1'b0;
            tmr     <= CLR_LOAD;
          end else if (tmr != 32'd0) begin
            tmr <= tmr - 32'd1;
          end
        end
        S_LOCKOUT: begin
          if (tmr == 32'd0) begin
            state   <= S_CLEAR;
            lockout <= 1'b0;
            tries   <= 3'd0;
            tmr     <= CLR_LOAD;
          end else begin
            tmr <= tmr - 32'd1;
          end
        end
        default: state <= S_CLEAR;
      endcase
    end
  end

endmodule

// File: tb/tb_safe_ctrl.sv
// Directed bench for safe_ctrl with short timer parameters.
module tb_safe_ctrl;

  logic       clk;
  logic       reset_n;
  logic       pass;
  logic       fail;
  logic       door_closed;
  logic       lock_en;
  logic       entry_clr_n;
  logic       lockout;
  logic [2:0] tries;
  logic [1:0] status;

  int tests;
  int fails;

  safe_ctrl #(
    .MAX_TRIES  (3),
    .UNLOCK_CYC (20),
    .LOCKOUT_CYC(50),
    .CLR_CYC    (4)
  ) dut (
    .clk        (clk),
    .reset_n    (reset_n),
    .pass       (pass),
    .fail       (fail),
    .door_closed(door_closed),
    .lock_en    (lock_en),
    .entry_clr_n(entry_clr_n),
    .lockout    (lockout),
    .tries      (tries),
    .status     (status)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic wait_status(input string tag, input logic [1:0] s, input int bound);
    int n;
    n = 0;
    while (status !== s && n < bound) begin
      tick();
      n++;
    end
    chk(tag, 32'(status), 32'(s));
  endtask

  initial begin
    int  cnt;
    logic seen_open;
    tests = 0;
    fails = 0;
    reset_n = 1'b0;
    pass = 1'b0;
    fail = 1'b0;
    door_closed = 1'b1;
    tick();
    tick();

    // Reset values
    chk("rst_status", 32'(status), 3);
    chk("rst_clr_n", 32'(entry_clr_n), 0);
    chk("rst_lock_en", 32'(lock_en), 0);
    chk("rst_tries", 32'(tries), 0);
    chk("rst_lockout", 32'(lockout), 0);

    // Release: entry_clr_n low for 4 cycles, then IDLE
    reset_n = 1'b1;
    cnt = 1;
    while (entry_clr_n === 1'b0 && cnt < 20) begin
      tick();
      if (entry_clr_n === 1'b0) cnt++;
    end
    chk("rst_clr_width", 32'(cnt), 4);
    chk("rst_to_idle", 32'(status), 0);
    chk("rst_lock_en_after", 32'(lock_en), 0);

    // Pass with door closed: exactly 20 cycles open, 4 cycles clear
    pass = 1'b1;
    tick();
    pass = 1'b0;
    chk("pass_status", 32'(status), 1);
    chk("pass_lock_en", 32'(lock_en), 1);
    chk("pass_clr_n", 32'(entry_clr_n), 0);
    chk("pass_tries", 32'(tries), 0);
    cnt = 1;
    while (lock_en === 1'b1 && cnt < 100) begin
      tick();
      if (lock_en === 1'b1) cnt++;
    end
    chk("pass_dwell", 32'(cnt), 20);
    chk("pass_then_clear", 32'(status), 3);
    cnt = 1;
    while (status === 2'b11 && cnt < 20) begin
      tick();
      if (status === 2'b11) cnt++;
    end
    chk("pass_clear_len", 32'(cnt), 4);
    chk("pass_idle", 32'(status), 0);
    chk("pass_idle_clr_n", 32'(entry_clr_n), 1);

    // Door held open past the timeout
    pass = 1'b1;
    tick();
    pass = 1'b0;
    door_closed = 1'b0;
    for (int i = 0; i < 40; i++) tick();
    chk("hold_lock_en", 32'(lock_en), 1);
    chk("hold_status", 32'(status), 1);
    door_closed = 1'b1;
    tick();
    chk("hold_close1", 32'(lock_en), 1);
    tick();
    chk("hold_close2", 32'(lock_en), 1);
    tick();
    chk("hold_close3", 32'(lock_en), 0);
    chk("hold_clear", 32'(status), 3);
    wait_status("hold_idle", 2'b00, 20);

    // Early close: open at cycle 2, close at cycle 6, relock at cycle 9
    pass = 1'b1;
    tick();
    pass = 1'b0;
    tick();
    tick();
    door_closed = 1'b0;
    for (int i = 0; i < 4; i++) tick();
    door_closed = 1'b1;
    tick();
    tick();
    chk("early_c8", 32'(lock_en), 1);
    tick();
    chk("early_c9", 32'(lock_en), 0);
    chk("early_clear", 32'(status), 3);
    wait_status("early_idle", 2'b00, 20);

    // Three fails -> lockout
    fail = 1'b1;
    tick();
    fail = 1'b0;
    chk("fail1_tries", 32'(tries), 1);
    chk("fail1_status", 32'(status), 3);
    wait_status("fail1_idle", 2'b00, 20);
    fail = 1'b1;
    tick();
    fail = 1'b0;
    chk("fail2_tries", 32'(tries), 2);
    wait_status("fail2_idle", 2'b00, 20);
    fail = 1'b1;
    tick();
    fail = 1'b0;
    chk("fail3_tries", 32'(tries), 3);
    chk("fail3_lockout", 32'(lockout), 1);
    chk("fail3_status", 32'(status), 2);
    chk("fail3_clr_n", 32'(entry_clr_n), 0);
    cnt = 1;
    seen_open = 1'b0;
    while (lockout === 1'b1 && cnt < 200) begin
      pass = (cnt == 10);
      tick();
      if (lock_en === 1'b1) seen_open = 1'b1;
      if (lockout === 1'b1) cnt++;
    end
    pass = 1'b0;
    chk("lockout_len", 32'(cnt), 50);
    chk("lockout_pass_ignored", 32'(seen_open), 0);
    chk("lockout_exit_status", 32'(status), 3);
    chk("lockout_exit_tries", 32'(tries), 0);
    wait_status("lockout_idle", 2'b00, 20);

    // Simultaneous pass and fail: pass wins
    pass = 1'b1;
    fail = 1'b1;
    tick();
    pass = 1'b0;
    fail = 1'b0;
    chk("simul_status", 32'(status), 1);
    chk("simul_tries", 32'(tries), 0);
    chk("simul_lockout", 32'(lockout), 0);
    wait_status("simul_idle", 2'b00, 100);

    // Stale fail level across CLEAR into IDLE
    fail = 1'b1;
    tick();
    chk("stale_tries1", 32'(tries), 1);
    wait_status("stale_idle", 2'b00, 20);
    for (int i = 0; i < 5; i++) tick();
    chk("stale_no_event", 32'(tries), 1);
    chk("stale_status", 32'(status), 0);
    fail = 1'b0;
    tick();
    fail = 1'b1;
    tick();
    fail = 1'b0;
    chk("stale_new_edge", 32'(tries), 2);
    wait_status("stale_idle2", 2'b00, 20);

    // Asynchronous reset while open relocks immediately
    pass = 1'b1;
    tick();
    pass = 1'b0;
    tick();
    chk("arst_open", 32'(lock_en), 1);
    reset_n = 1'b0;
    #1;
    chk("arst_lock_en", 32'(lock_en), 0);
    chk("arst_status", 32'(status), 3);
    chk("arst_tries", 32'(tries), 0);
    tick();
    reset_n = 1'b1;
    wait_status("arst_idle", 2'b00, 20);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
